// File: rtl/reg_file_scoreboard_if.sv
// reg_file_scoreboard_if -- bundle of the read, writeback and issue signals
// of the register file scoreboard.
//   rd_addr      : NUM_RD packed read indices, port i at [i*ADDR_W +: ADDR_W]
//   rd_data      : NUM_RD packed read data, port i at [i*DATA_W +: DATA_W]
//   rd_busy      : per read port, source register is reserved
//   wr_en/wr_addr/wr_data : writeback strobe, index and data
//   iss_en/iss_addr       : issue strobe and destination index to reserve
//   flush        : clear all reservations
//   iss_conflict : issue targets an already-reserved register
//   busy_cnt     : number of reserved registers
// master = the pipeline driving the scoreboard, slave = the scoreboard.
interface reg_file_scoreboard_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     flush;
  logic                     iss_conflict;
  logic [ADDR_W:0]          busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input  rd_data, rd_busy, iss_conflict, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rd_data, rd_busy, iss_conflict, busy_cnt
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard -- register file with per-register busy (reservation)
// bits for hazard tracking.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; clears data, busy bits and count
//   bus   : reg_file_scoreboard_if.slave (reads, writeback, issue, flush,
//           conflict flag and reserved-register count)
// Register 0 is hardwired to zero and can never be reserved. Reads are
// combinational with write-through bypass; a same-cycle writeback also
// releases the read hazard combinationally.
module reg_file_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NUM_RD = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  reg_file_scoreboard_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;

  // Entries need an asynchronous clear, so the file is built from flops.
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [ADDR_W:0]   r_busy_cnt;

  logic [DEPTH-1:0]  w_busy_next;
  logic [ADDR_W:0]   w_busy_cnt_next;
  logic              w_wr_act;
  logic              w_iss_act;
  logic              w_set_new;
  logic              w_clr_old;

  // Register 0 is excluded from both writeback and issue.
  assign w_wr_act  = bus.wr_en  && (bus.wr_addr  != '0);
  assign w_iss_act = bus.iss_en && (bus.iss_addr != '0);

  assign bus.iss_conflict = w_iss_act && r_busy[bus.iss_addr] &&
                            !(w_wr_act && (bus.wr_addr == bus.iss_addr));
  assign bus.busy_cnt = r_busy_cnt;

  // Read ports: bypass the writeback data, and let a same-cycle writeback
  // release the busy flag.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      logic [ADDR_W-1:0] ra;
      logic              byp;
      ra  = bus.rd_addr[p*ADDR_W +: ADDR_W];
      byp = w_wr_act && (bus.wr_addr == ra);
      bus.rd_data[p*DATA_W +: DATA_W] = byp ? bus.wr_data : r_mem[ra];
      bus.rd_busy[p] = r_busy[ra] && !byp;
    end
  end

  // Busy vector: flush clears everything, writeback clears its bit, issue
  // sets its bit last so a same-edge issue beats the writeback.
  always_comb begin
    w_busy_next = r_busy;
    if (bus.flush) begin
      w_busy_next = '0;
    end else if (w_wr_act) begin
      w_busy_next[bus.wr_addr] = 1'b0;
    end
    if (w_iss_act) begin
      w_busy_next[bus.iss_addr] = 1'b1;
    end
  end

  // Count tracks the vector incrementally: a newly reserved register adds
  // one, a released one (not re-reserved on the same edge) subtracts one.
  assign w_set_new = w_iss_act && !r_busy[bus.iss_addr];
  assign w_clr_old = w_wr_act && r_busy[bus.wr_addr] &&
                     !(w_iss_act && (bus.iss_addr == bus.wr_addr));

  always_comb begin
    w_busy_cnt_next = r_busy_cnt;
    if (bus.flush) begin
      w_busy_cnt_next = {{ADDR_W{1'b0}}, w_iss_act};
    end else begin
      w_busy_cnt_next = r_busy_cnt + {{ADDR_W{1'b0}}, w_set_new}
                                   - {{ADDR_W{1'b0}}, w_clr_old};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_next;
      r_busy_cnt <= w_busy_cnt_next;
    end
  end

  // Entry 0 is only ever reset, so it always reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_mem[e] <= '0;
      end
    end else if (w_wr_act) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end
endmodule

// File: tb/tb_reg_file_scoreboard.sv
module tb_reg_file_scoreboard;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_file_scoreboard_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_RD(NR)) bus ();

  reg_file_scoreboard #(.ADDR_W(AW), .DATA_W(DW), .NUM_RD(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: architectural register contents and reservation set.
  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_busy [DEPTH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += m_busy[i] ? 1 : 0;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic set_in(input logic we, input int wa, input logic [DW-1:0] wd,
                        input logic ie, input int ia, input logic fl,
                        input int ra0, input int ra1);
    bus.wr_en    = we;
    bus.wr_addr  = AW'(wa);
    bus.wr_data  = wd;
    bus.iss_en   = ie;
    bus.iss_addr = AW'(ia);
    bus.flush    = fl;
    bus.rd_addr  = {AW'(ra1), AW'(ra0)};
  endtask

  // Expected combinational outputs from the model and the current inputs.
  task automatic check_comb(input string tag);
    int wa, ia, ra, cnt;
    logic wact, byp, exp_b, exp_c;
    logic [DW-1:0] exp_d;
    wa = int'(bus.wr_addr);
    ia = int'(bus.iss_addr);
    wact = bus.wr_en && (wa != 0);
    for (int p = 0; p < NR; p++) begin
      ra = int'(bus.rd_addr[p*AW +: AW]);
      byp = wact && (wa == ra);
      exp_d = byp ? bus.wr_data : ((ra == 0) ? '0 : m_mem[ra]);
      exp_b = (ra != 0) && m_busy[ra] && !byp;
      check($sformatf("%s_rd_data%0d", tag, p), 64'(bus.rd_data[p*DW +: DW]), 64'(exp_d));
      check($sformatf("%s_rd_busy%0d", tag, p), 64'(bus.rd_busy[p]), 64'(exp_b));
    end
    exp_c = bus.iss_en && (ia != 0) && m_busy[ia] && !(wact && wa == ia);
    check({tag, "_conflict"}, 64'(bus.iss_conflict), 64'(exp_c));
    cnt = model_count();
    check({tag, "_busy_cnt"}, 64'(bus.busy_cnt), 64'(cnt));
  endtask

  // Architectural effect of one clock edge.
  task automatic model_edge();
    int wa, ia;
    if (!rst_n) return;
    wa = int'(bus.wr_addr);
    ia = int'(bus.iss_addr);
    if (bus.flush)
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
    if (bus.wr_en && wa != 0) begin
      m_mem[wa] = bus.wr_data;
      if (!bus.flush) m_busy[wa] = 1'b0;
    end
    if (bus.iss_en && ia != 0) m_busy[ia] = 1'b1;
  endtask

  // Inputs are applied at posedge+1; outputs checked at negedge; model
  // advances on the posedge.
  task automatic step(input string tag);
    @(negedge clk);
    check_comb(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    model_reset();
    set_in(0, 0, '0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_comb("reset");
    #2 rst_n = 1'b1;

    // Write r5, read it back the next cycle.
    set_in(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0); step("wr5");
    set_in(0, 0, '0, 0, 0, 0, 5, 0);           step("rd5");
    check("rd5_direct", 64'(bus.rd_data[DW-1:0]), 64'hDEADBEEF);

    // Bypass on port 1 before the edge.
    set_in(1, 7, 32'h12345678, 0, 0, 0, 0, 7);
    #1 check("byp7_direct", 64'(bus.rd_data[DW +: DW]), 64'h12345678);
    step("byp7");

    // Issue r3, observe busy, then writeback releases it.
    set_in(0, 0, '0, 1, 3, 0, 0, 0);           step("iss3");
    set_in(0, 0, '0, 0, 0, 0, 3, 0);           step("busy3");
    set_in(1, 3, 32'hA5A5A5A5, 0, 0, 0, 3, 3); step("wb3");
    set_in(0, 0, '0, 0, 0, 0, 3, 0);           step("after_wb3");

    // Double issue of r4.
    set_in(0, 0, '0, 1, 4, 0, 4, 0);           step("iss4a");
    set_in(0, 0, '0, 1, 4, 0, 4, 0);
    #1 check("iss4_conflict_direct", 64'(bus.iss_conflict), 64'd1);
    step("iss4b");
    set_in(0, 0, '0, 0, 0, 0, 4, 0);           step("after_iss4");

    // Same-edge issue and writeback to r8: set wins, data still stored.
    set_in(1, 8, 32'h0BADF00D, 1, 8, 0, 8, 0); step("iss_wb8");
    set_in(0, 0, '0, 0, 0, 0, 8, 8);           step("after8");

    // Issue r1, r2, r6, then flush with an issue to r9.
    set_in(0, 0, '0, 1, 1, 0, 1, 2);           step("iss1");
    set_in(0, 0, '0, 1, 2, 0, 1, 2);           step("iss2");
    set_in(0, 0, '0, 1, 6, 0, 6, 5);           step("iss6");
    set_in(0, 0, '0, 1, 9, 1, 9, 5);           step("flush9");
    set_in(0, 0, '0, 0, 0, 0, 9, 6);           step("after_flush");
    check("flush_cnt_direct", 64'(bus.busy_cnt), 64'd1);

    // Register 0: writes and issues ignored.
    set_in(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0); step("r0_wr_iss");
    set_in(0, 0, '0, 0, 0, 0, 0, 0);           step("r0_after");

    // Randomized traffic with a mid-sequence asynchronous reset.
    for (int n = 0; n < 400; n++) begin
      int ra0, ra1;
      if (n == 200) begin
        set_in(0, 0, '0, 0, 0, 0, $urandom_range(0, 9), $urandom_range(0, 9));
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_comb("async_rst");
        check("async_rst_cnt_direct", 64'(bus.busy_cnt), 64'd0);
        for (int k = 0; k < 3; k++) begin
          ra0 = $urandom_range(0, 9);
          set_in($urandom_range(0, 1), $urandom_range(0, 9), $urandom,
                 $urandom_range(0, 1), $urandom_range(0, 9), $urandom_range(0, 1),
                 ra0, ra0);
          step("in_rst");
        end
        set_in(0, 0, '0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
      end
      ra0 = $urandom_range(0, 9);
      ra1 = ($urandom_range(0, 3) == 0) ? ra0 : $urandom_range(0, 9);
      set_in($urandom_range(0, 1), $urandom_range(0, 9), $urandom,
             ($urandom_range(0, 2) != 0), $urandom_range(0, 9),
             ($urandom_range(0, 24) == 0), ra0, ra1);
      step("rand");
    end

    set_in(0, 0, '0, 0, 0, 0, 0, 0);
    step("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
